gate_function_identifier: RTL and testbench
===========================================

Name: gate_function_identifier

Overview:
- Sequential probe/decoder: drives both inputs of a 2-input combinational gate block, captures the gate's output for all four input vectors, and decodes which logic function it implements.
- Sits beside our gate/MUX combinational blocks as a self-check engine: probes drive the block's a/b, and dut_y returns one selected output.
- Produces a 4-bit truth table, a gate code, a match flag, and a one-cycle done pulse.

Parameters:
SETTLE_CYCLES, 2, cycles each probe vector is held before sampling dut_y; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  synchronous cancel of a running sweep
dut_y  input  1  output of the gate under test
probe_a  output  1  drives gate input a
probe_b  output  1  drives gate input b
busy  output  1  high from the cycle after start is accepted until DECODE completes
done  output  1  one-cycle pulse; result valid
truth_table  output  4  tt[{a,b}] = sampled dut_y; bit0 = (a=0,b=0), bit3 = (a=1,b=1)
gate_code  output  3  0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 UNKNOWN
match  output  1  high when gate_code != 7
unstable  output  1  stability-check failure flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE; probe_a=probe_b=0; busy=0; done=0; truth_table=0; gate_code=7; match=0; unstable=0; vector index and settle counter = 0.
- All outputs are registered. Probes change only on clock edges.
- States: IDLE, SETTLE, SAMPLE, DECODE.
- IDLE: when start=1, load probes=00 and idx=0, clear cnt, truth_table and unstable, set busy=1, and go to SETTLE. start is ignored in every other state.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE. The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: truth_table[idx] <= dut_y.
  - If idx==3, go to DECODE.
  - Otherwise idx increments, {probe_a,probe_b} <= idx+1, cnt is cleared, and the block returns to SETTLE.
  - Vector order: 00, 01, 10, 11.
- DECODE: truth table to gate code mapping:
  - 1000 -> 0 (AND)
  - 0111 -> 1 (NAND)
  - 1110 -> 2 (OR)
  - 0001 -> 3 (NOR)
  - 0110 -> 4 (XOR)
  - 1001 -> 5 (XNOR)
  - 0011 -> 6 (NOT_A)
  - anything else -> 7 (UNKNOWN)
  - In the same edge: match set, done=1, busy=0, probes=00, next state IDLE. done clears on the following edge.
- Latency: done is high 4*(SETTLE_CYCLES+1)+1 clock edges after the edge that accepted start (13 for the default).
- start asserted in the same cycle done is high is accepted; a back-to-back sweep is legal.
- abort=1 in SETTLE or SAMPLE: the next edge returns to IDLE with probes=00 and busy=0. No done pulse is generated. gate_code, match and truth_table keep their partial or cleared values. abort has priority over a SAMPLE transition. abort in IDLE or DECODE has no effect.
- rst mid-sweep: immediate return to reset values. No done pulse.
- gate_code, match and truth_table hold their values until the next accepted start.

Optional Feature:
- Macro: GATE_ID_STABILITY_CHECK_EN.
- When defined:
  - dut_y is additionally captured on the first SETTLE cycle of each vector (after the probe change has propagated one cycle).
  - In SAMPLE, if that capture differs from the final sample, unstable is set sticky for the sweep.
  - In DECODE, unstable=1 forces gate_code=7 and match=0; truth_table still shows the final samples.
- When not defined: no extra capture logic, and unstable is tied 0.
- Port list is identical in both builds.

Test Plan:
- AND model on dut_y, SETTLE_CYCLES=2, start pulse -> done exactly 13 edges later, truth_table=1000, gate_code=0, match=1, busy low in the done cycle.
- Sequential sweeps with XOR then NOT_A models, start re-asserted in the done cycle -> first result 0110/code 4, second result 0011/code 6, no idle gap.
- dut_y tied 1 -> truth_table=1111, gate_code=7, match=0.
- abort asserted during SETTLE of vector 10 -> no done pulse, busy=0 and probes=00 next edge; a subsequent start yields a correct NOR result (0001/code 3).
- rst asserted asynchronously mid-sweep (between edges) -> all outputs at reset values immediately; start asserted during busy is ignored (no restart, latency unchanged).
- With GATE_ID_STABILITY_CHECK_EN: OR model whose output toggles once inside the settle window of vector 01 -> unstable=1, gate_code=7, match=0. Without the macro: same stimulus gives unstable=0.

Source files
------------

// File: rtl/gate_function_identifier.sv
// Sweeps a 2-input gate through 00,01,10,11, captures its output and decodes the logic function.
// Optional macro GATE_ID_STABILITY_CHECK_EN adds an early-vs-final sample stability check.
module gate_function_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_y,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       match,
  output logic       unstable
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DECODE = 2'd3;
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] CODE_UNKNOWN = 3'd7;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       probe_a_q, probe_a_d, probe_b_q, probe_b_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] code_q, code_d;
  logic       match_q, match_d;
`ifdef GATE_ID_STABILITY_CHECK_EN
  logic       early_q, early_d;
  logic       unstable_q, unstable_d;
`endif

  function automatic logic [2:0] decode_tt(input logic [3:0] tt);
    case (tt)
      4'b1000: decode_tt = 3'd0;
      4'b0111: decode_tt = 3'd1;
      4'b1110: decode_tt = 3'd2;
      4'b0001: decode_tt = 3'd3;
      4'b0110: decode_tt = 3'd4;
      4'b1001: decode_tt = 3'd5;
      4'b0011: decode_tt = 3'd6;
      default: decode_tt = CODE_UNKNOWN;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    probe_a_d = probe_a_q;
    probe_b_d = probe_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tt_d      = tt_q;
    code_d    = code_q;
    match_d   = match_q;
`ifdef GATE_ID_STABILITY_CHECK_EN
    early_d    = early_q;
    unstable_d = unstable_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETTLE;
          probe_a_d = 1'b0;
          probe_b_d = 1'b0;
          idx_d     = 2'd0;
          cnt_d     = 8'd0;
          tt_d      = 4'b0000;
          busy_d    = 1'b1;
`ifdef GATE_ID_STABILITY_CHECK_EN
          unstable_d = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d   = S_IDLE;
          probe_a_d = 1'b0;
          probe_b_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
`ifdef GATE_ID_STABILITY_CHECK_EN
          // First settle cycle: probes have had one cycle to propagate.
          if (cnt_q == 8'd0) early_d = dut_y;
`endif
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d   = S_IDLE;
          probe_a_d = 1'b0;
          probe_b_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          tt_d[idx_q] = dut_y;
`ifdef GATE_ID_STABILITY_CHECK_EN
          if (early_q != dut_y) unstable_d = 1'b1;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_DECODE;
          end else begin
            idx_d                  = idx_q + 2'd1;
            {probe_a_d, probe_b_d} = idx_q + 2'd1;
            cnt_d                  = 8'd0;
            state_d                = S_SETTLE;
          end
        end
      end
      default: begin
`ifdef GATE_ID_STABILITY_CHECK_EN
        code_d = unstable_q ? CODE_UNKNOWN : decode_tt(tt_q);
`else
        code_d = decode_tt(tt_q);
`endif
        match_d   = (code_d != CODE_UNKNOWN);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        probe_a_d = 1'b0;
        probe_b_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= 2'd0;
      probe_a_q <= 1'b0;
      probe_b_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_q      <= 4'b0000;
      code_q    <= CODE_UNKNOWN;
      match_q   <= 1'b0;
`ifdef GATE_ID_STABILITY_CHECK_EN
      early_q    <= 1'b0;
      unstable_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      probe_a_q <= probe_a_d;
      probe_b_q <= probe_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tt_q      <= tt_d;
      code_q    <= code_d;
      match_q   <= match_d;
`ifdef GATE_ID_STABILITY_CHECK_EN
      early_q    <= early_d;
      unstable_q <= unstable_d;
`endif
    end
  end

  assign probe_a     = probe_a_q;
  assign probe_b     = probe_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_code   = code_q;
  assign match       = match_q;
`ifdef GATE_ID_STABILITY_CHECK_EN
  assign unstable = unstable_q;
`else
  assign unstable = 1'b0;
`endif

endmodule

// File: tb/tb_gate_function_identifier.sv
// Bench for gate_function_identifier: gate model driven by a truth table, table and random sweeps.
module tb_gate_function_identifier;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       dut_y;
  logic       probe_a, probe_b, busy, done, match, unstable;
  logic [3:0] truth_table;
  logic [2:0] gate_code;
  logic [3:0] model_tt = 4'b0000;
  logic       glitch = 1'b0;
  bit         glitch_arm = 1'b0;
  int         checks = 0;
  int         failures = 0;

  gate_function_identifier #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(dut_y),
    .probe_a(probe_a), .probe_b(probe_b), .busy(busy), .done(done),
    .truth_table(truth_table), .gate_code(gate_code), .match(match),
    .unstable(unstable)
  );

  always #5 clk = ~clk;

  // Combinational gate under test, optionally corrupted for one cycle.
  assign dut_y = model_tt[{probe_a, probe_b}] ^ glitch;

  // One-cycle glitch covering the first settle cycle of vector 01.
  always @(posedge clk) begin
    #1;
    if (glitch) glitch = 1'b0;
    else if (glitch_arm && !probe_a && probe_b) begin
      glitch     = 1'b1;
      glitch_arm = 1'b0;
    end
  end

  typedef struct {
    logic [3:0] tt;
    logic [2:0] code;
    logic       m;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference decode: position in the list of known truth tables is the code.
  function automatic logic [2:0] ref_code(input logic [3:0] tt);
    logic [3:0] known [7];
    known = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011};
    ref_code = 3'd7;
    for (int i = 0; i < 7; i++) if (known[i] == tt) ref_code = 3'(i);
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, "_probe_a"}, probe_a, 0);
    chk({nm, "_probe_b"}, probe_b, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_tt"}, truth_table, 0);
    chk({nm, "_code"}, gate_code, 7);
    chk({nm, "_match"}, match, 0);
    chk({nm, "_unstable"}, unstable, 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic chk_result(input string nm, input int n, input int exp_n, input logic [3:0] tt,
                            input logic [2:0] code, input logic m, input logic u);
    chk({nm, "_latency"}, n, exp_n);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_tt"}, truth_table, tt);
    chk({nm, "_code"}, gate_code, code);
    chk({nm, "_match"}, match, m);
    chk({nm, "_unstable"}, unstable, u);
  endtask

  initial begin
    int  n;
    int  seen;
    logic [3:0] rt;
    logic [2:0] rc;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{4'b1000, 3'd0, 1'b1};
    vecs[1] = '{4'b0111, 3'd1, 1'b1};
    vecs[2] = '{4'b1110, 3'd2, 1'b1};
    vecs[3] = '{4'b0001, 3'd3, 1'b1};
    vecs[4] = '{4'b0110, 3'd4, 1'b1};
    vecs[5] = '{4'b1001, 3'd5, 1'b1};
    vecs[6] = '{4'b0011, 3'd6, 1'b1};
    vecs[7] = '{4'b1111, 3'd7, 1'b0};
    vecs[8] = '{4'b0000, 3'd7, 1'b0};
    vecs[9] = '{4'b0101, 3'd7, 1'b0};

    for (int i = 0; i < 10; i++) begin
      model_tt = vecs[i].tt;
      launch();
      wait_done(n);
      chk_result($sformatf("vec%0d", i), n, 13, vecs[i].tt, vecs[i].code, vecs[i].m, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_clears", i), done, 0);
    end

    // Back-to-back: XOR then NOT_A with start held during the done cycle.
    model_tt = 4'b0110;
    launch();
    wait_done(n);
    chk_result("b2b_xor", n, 13, 4'b0110, 3'd4, 1'b1, 1'b0);
    model_tt = 4'b0011;
    launch();
    wait_done(n);
    chk_result("b2b_nota", n, 13, 4'b0011, 3'd6, 1'b1, 1'b0);
    @(negedge clk);

    // Abort during settle of vector 10.
    model_tt = 4'b1000;
    launch();
    n = 0;
    while (!(probe_a && !probe_b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_vec10", {probe_a, probe_b}, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_probes", {probe_a, probe_b}, 2'b00);
    chk("abort_code_held", gate_code, 6);
    chk("abort_tt_partial", truth_table, 4'b0000);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    model_tt = 4'b0001;
    launch();
    wait_done(n);
    chk_result("after_abort_nor", n, 13, 4'b0001, 3'd3, 1'b1, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-sweep.
    model_tt = 4'b1110;
    launch();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start during busy is ignored.
    model_tt = 4'b1001;
    launch();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk_result("start_ignored", n, 8, 4'b1001, 3'd5, 1'b1, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rt = 4'($urandom_range(0, 15));
      rc = ref_code(rt);
      model_tt = rt;
      launch();
      wait_done(n);
      chk_result($sformatf("rand%0d", i), n, 13, rt, rc, rc != 3'd7, 1'b0);
      @(negedge clk);
    end

    // OR gate glitching once inside the settle window of vector 01.
    model_tt   = 4'b1110;
    glitch_arm = 1'b1;
    launch();
    wait_done(n);
`ifdef GATE_ID_STABILITY_CHECK_EN
    chk_result("glitch_or", n, 13, 4'b1110, 3'd7, 1'b0, 1'b1);
`else
    chk_result("glitch_or", n, 13, 4'b1110, 3'd2, 1'b1, 1'b0);
`endif
    @(negedge clk);
    launch();
    wait_done(n);
    chk_result("clean_or", n, 13, 4'b1110, 3'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
